// File: rtl/prio_req_encoder.sv
// Sequential priority encoder: latches request pulses, offers the winning index on valid/ready.
// Optional PRIO_ENC_MASK_EN adds mask_i, which hides pending sources from arbitration.
module prio_req_encoder #(
    parameter int N         = 8,
    parameter int LSB_FIRST = 0,
    parameter int CW        = 8,
    localparam int W        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic [N-1:0]  req_i,
`ifdef PRIO_ENC_MASK_EN
    input  logic [N-1:0]  mask_i,
`endif
    input  logic          ready_i,
    output logic          valid_o,
    output logic [W-1:0]  idx_o,
    output logic [N-1:0]  pend_o,
    output logic [CW-1:0] drop_cnt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_valid;
    logic [W-1:0]  r_idx;
    logic [N-1:0]  r_pend;
    logic [CW-1:0] r_drop;

    logic          w_accept;
    logic [N-1:0]  w_clrMask;
    logic [N-1:0]  w_pendNext;
    logic          w_collide;
    logic [N-1:0]  w_elig;
    logic [W-1:0]  w_win;

    assign w_accept   = r_valid & ready_i;
    assign w_clrMask  = w_accept ? (N'(1) << r_idx) : '0;
    assign w_pendNext = (r_pend & ~w_clrMask) | req_i;
    // The source being cleared this cycle is not a collision: its re-request simply re-pends it.
    assign w_collide  = |(req_i & r_pend & ~w_clrMask);

`ifdef PRIO_ENC_MASK_EN
    assign w_elig = r_pend & ~mask_i;
`else
    assign w_elig = r_pend;
`endif

    always_comb begin
        w_win = '0;
        if (LSB_FIRST != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (w_elig[i]) w_win = W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_elig[i]) w_win = W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_pend  <= '0;
            r_drop  <= '0;
        end else if (clear_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_pend  <= '0;
            r_drop  <= '0;
        end else begin
            r_pend <= w_pendNext;
            if (w_collide && (r_drop != {CW{1'b1}})) begin
                r_drop <= r_drop + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (|w_elig) begin
                        r_idx   <= w_win;
                        r_valid <= 1'b1;
                        r_state <= OFFER;
                    end
                end
                OFFER: begin
                    // The offered index stays frozen until it is accepted.
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign valid_o    = r_valid;
    assign idx_o      = r_idx;
    assign pend_o     = r_pend;
    assign drop_cnt_o = r_drop;

endmodule

// File: tb/tb_prio_req_encoder.sv
// Scoreboard bench for prio_req_encoder: default, LSB_FIRST=1 and CW=2 instances.
// Expected grants are queued at stimulus time and popped on each accepted handshake.
module tb_prio_req_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clearAll = 1'b0;

    logic [7:0] reqA = 8'h00;
    logic       readyA = 1'b0;
    logic       validA;
    logic [2:0] idxA;
    logic [7:0] pendA;
    logic [7:0] dropA;

    logic [7:0] reqL = 8'h00;
    logic       readyL = 1'b0;
    logic       validL;
    logic [2:0] idxL;
    logic [7:0] pendL;
    logic [7:0] dropL;

    logic [7:0] reqS = 8'h00;
    logic       readyS = 1'b0;
    logic       validS;
    logic [2:0] idxS;
    logic [7:0] pendS;
    logic [1:0] dropS;

`ifdef PRIO_ENC_MASK_EN
    logic [7:0] maskA = 8'h00;
    logic [7:0] maskOff = 8'h00;
`endif

    int checkCount = 0;
    int errCount = 0;
    int expA[$];
    int expL[$];

    always #5 clk = ~clk;

    prio_req_encoder #(.N(8), .LSB_FIRST(0), .CW(8)) dut (
        .clk(clk), .rst(rst), .clear_i(clearAll), .req_i(reqA),
`ifdef PRIO_ENC_MASK_EN
        .mask_i(maskA),
`endif
        .ready_i(readyA), .valid_o(validA), .idx_o(idxA), .pend_o(pendA), .drop_cnt_o(dropA)
    );

    prio_req_encoder #(.N(8), .LSB_FIRST(1), .CW(8)) dutLsb (
        .clk(clk), .rst(rst), .clear_i(clearAll), .req_i(reqL),
`ifdef PRIO_ENC_MASK_EN
        .mask_i(maskOff),
`endif
        .ready_i(readyL), .valid_o(validL), .idx_o(idxL), .pend_o(pendL), .drop_cnt_o(dropL)
    );

    prio_req_encoder #(.N(8), .LSB_FIRST(0), .CW(2)) dutSat (
        .clk(clk), .rst(rst), .clear_i(clearAll), .req_i(reqS),
`ifdef PRIO_ENC_MASK_EN
        .mask_i(maskOff),
`endif
        .ready_i(readyS), .valid_o(validS), .idx_o(idxS), .pend_o(pendS), .drop_cnt_o(dropS)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant monitors: every accepted handshake must match the next queued index.
    always @(negedge clk) begin
        if (validA && readyA) begin
            if (expA.size() == 0) checkOutput("grantA unexpected", 64'(idxA), 64'hFFFF);
            else checkOutput("grantA", 64'(idxA), 64'(expA.pop_front()));
        end
        if (validL && readyL) begin
            if (expL.size() == 0) checkOutput("grantL unexpected", 64'(idxL), 64'hFFFF);
            else checkOutput("grantL", 64'(idxL), 64'(expL.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus();
        // Reset with requests held high.
        reqA = 8'hFF; reqL = 8'hFF; reqS = 8'hFF;
        step(); step();
        checkOutput("rst valid", 64'(validA), 64'd0);
        checkOutput("rst idx", 64'(idxA), 64'd0);
        checkOutput("rst pend", 64'(pendA), 64'd0);
        checkOutput("rst drop", 64'(dropA), 64'd0);
        rst = 1'b0; reqA = 8'h00; reqL = 8'h00; reqS = 8'h00;
        step();
        checkOutput("post rst pend", 64'(pendA), 64'd0);

        // Order: 8'h24 -> idx 5 then idx 2.
        expA.push_back(5); expA.push_back(2);
        reqA = 8'h24; readyA = 1'b1;
        step(); reqA = 8'h00;
        checkOutput("order pend", 64'(pendA), 64'h24);
        checkOutput("order latency", 64'(validA), 64'd0);
        step();
        checkOutput("order valid1", 64'(validA), 64'd1);
        checkOutput("order idx1", 64'(idxA), 64'd5);
        step();
        checkOutput("order bubble", 64'(validA), 64'd0);
        checkOutput("order pend2", 64'(pendA), 64'h04);
        step();
        checkOutput("order idx2", 64'(idxA), 64'd2);
        step();
        checkOutput("order done valid", 64'(validA), 64'd0);
        checkOutput("order done pend", 64'(pendA), 64'd0);

        // Hold: a higher-priority arrival does not preempt the offer.
        expA.push_back(2); expA.push_back(7);
        readyA = 1'b0; reqA = 8'h04;
        step(); reqA = 8'h00;
        step();
        checkOutput("hold idx", 64'(idxA), 64'd2);
        reqA = 8'h80;
        step(); reqA = 8'h00;
        checkOutput("hold pend", 64'(pendA), 64'h84);
        checkOutput("hold idx frozen", 64'(idxA), 64'd2);
        step();
        checkOutput("hold still valid", 64'(validA), 64'd1);
        readyA = 1'b1;
        step();
        checkOutput("hold bubble", 64'(validA), 64'd0);
        checkOutput("hold pend after", 64'(pendA), 64'h80);
        step();
        checkOutput("hold idx7", 64'(idxA), 64'd7);
        checkOutput("hold valid7", 64'(validA), 64'd1);
        step(); readyA = 1'b0;
        checkOutput("hold drop", 64'(dropA), 64'd0);

        // Collisions count once per cycle; accept-cycle set re-pends without counting.
        expA.push_back(3); expA.push_back(3); expA.push_back(0);
        reqA = 8'h09;
        step();
        checkOutput("coll pend", 64'(pendA), 64'h09);
        step();
        checkOutput("coll drop once", 64'(dropA), 64'd1);
        checkOutput("coll idx", 64'(idxA), 64'd3);
        readyA = 1'b1; reqA = 8'h08;
        step(); reqA = 8'h00;
        checkOutput("accept-set pend", 64'(pendA), 64'h09);
        checkOutput("accept-set drop", 64'(dropA), 64'd1);
        step();
        checkOutput("reoffer idx", 64'(idxA), 64'd3);
        step(); step();
        checkOutput("coll idx0", 64'(idxA), 64'd0);
        step(); readyA = 1'b0;
        checkOutput("coll done pend", 64'(pendA), 64'd0);

        // Synchronous clear during an offer overrides simultaneous requests.
        reqA = 8'h10;
        step();
        step();
        checkOutput("clr pre drop", 64'(dropA), 64'd2);
        checkOutput("clr pre idx", 64'(idxA), 64'd4);
        clearAll = 1'b1; reqA = 8'hFF;
        step(); clearAll = 1'b0; reqA = 8'h00;
        checkOutput("clr pend", 64'(pendA), 64'd0);
        checkOutput("clr valid", 64'(validA), 64'd0);
        checkOutput("clr drop", 64'(dropA), 64'd0);
        checkOutput("clr idx kept", 64'(idxA), 64'd4);
        step();
        checkOutput("clr stays idle", 64'(validA), 64'd0);

`ifdef PRIO_ENC_MASK_EN
        // Masked source stays pending while the unmasked one is offered.
        expA.push_back(0);
        maskA = 8'h80; reqA = 8'h81; readyA = 1'b1;
        step(); reqA = 8'h00;
        step();
        checkOutput("mask idx", 64'(idxA), 64'd0);
        step();
        checkOutput("mask pend", 64'(pendA), 64'h80);
        step(); readyA = 1'b0;
        checkOutput("mask no offer", 64'(validA), 64'd0);
        clearAll = 1'b1;
        step(); clearAll = 1'b0; maskA = 8'h00;
`endif

        // Reset mid-offer: outputs drop at once and the request is lost.
        reqA = 8'h02;
        step(); reqA = 8'h00;
        step();
        checkOutput("rst-mid idx", 64'(idxA), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst-mid valid", 64'(validA), 64'd0);
        checkOutput("rst-mid pend", 64'(pendA), 64'd0);
        #2 rst = 1'b0;
        step(); step();
        checkOutput("rst-mid lost", 64'(validA), 64'd0);

        // LSB_FIRST=1: lowest index wins.
        expL.push_back(2); expL.push_back(5);
        reqL = 8'h24; readyL = 1'b1;
        step(); reqL = 8'h00;
        step();
        checkOutput("lsb idx first", 64'(idxL), 64'd2);
        step(); step();
        checkOutput("lsb idx second", 64'(idxL), 64'd5);
        step(); readyL = 1'b0;
        checkOutput("lsb pend done", 64'(pendL), 64'd0);

        // CW=2 drop counter saturation.
        reqS = 8'h08;
        step();
        checkOutput("sat first set", 64'(dropS), 64'd0);
        step(); step();
        checkOutput("sat count2", 64'(dropS), 64'd2);
        step(); step(); step();
        checkOutput("sat held", 64'(dropS), 64'd3);
        checkOutput("sat offer idx", 64'(idxS), 64'd3);
        readyS = 1'b1;
        step(); reqS = 8'h00;
        checkOutput("sat accept drop", 64'(dropS), 64'd3);
        checkOutput("sat accept pend", 64'(pendS), 64'h08);
        step();
        checkOutput("sat reoffer", 64'(validS), 64'd1);
        step(); readyS = 1'b0;
        checkOutput("sat pend done", 64'(pendS), 64'd0);
        step();
    endtask

    initial begin
        applyStimulus();
        checkOutput("queueA drained", 64'(expA.size()), 64'd0);
        checkOutput("queueL drained", 64'(expL.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
